tele_cmd_tx: RTL

- Transmit side of the remote power-control interface. Turns a single command request (power on, power off, reset) into timed active-low request pulses with an activity qualifier.
- The pulses meet the far-end requirements: 2-flop synchroniser, qualifier low while the command line is low.
- Sits in the 32 kHz always-on domain of the companion/BMC-emulation CPLD. Drives the board-level request lines that the power-control receiver samples.

---
 rtl/tele_cmd_tx_pkg.sv | 36 +++
 rtl/tele_cmd_tx_if.sv | 24 ++
 rtl/tele_tx_timer.sv | 37 +++
 rtl/tele_cmd_tx.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tele_cmd_tx_pkg.sv
// Shared definitions for the telemetry command transmitter: command codes,
// FSM state encoding and default pulse timing (also used by the receiver bench).
package tele_cmd_tx_pkg;

  typedef logic [1:0] tele_cmd_t;

  localparam tele_cmd_t CMD_PWRON  = 2'b00;
  localparam tele_cmd_t CMD_PWROFF = 2'b01;
  localparam tele_cmd_t CMD_RESET  = 2'b10;
  localparam tele_cmd_t CMD_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_e;

  localparam int DEF_PULSE_W = 16;
  localparam int DEF_SETUP_W = 4;
  localparam int DEF_HOLD_W  = 4;
  localparam int DEF_GAP_W   = 32;
  localparam int DEF_CNT_W   = 8;

  // One-hot request line select, ordered {PWROn, PWROff, Reset}.
  function automatic logic [2:0] cmd_line_mask(input tele_cmd_t cmd);
    case (cmd)
      CMD_PWRON:  cmd_line_mask = 3'b100;
      CMD_PWROFF: cmd_line_mask = 3'b010;
      CMD_RESET:  cmd_line_mask = 3'b001;
      default:    cmd_line_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tele_cmd_tx_if.sv
// Command request handshake between a requester (master) and tele_cmd_tx (slave).
interface tele_cmd_tx_if;
  import tele_cmd_tx_pkg::*;

  logic      i_cmd_valid;
  tele_cmd_t i_cmd;
  logic      o_cmd_ready;
  logic      o_cmd_err;

  modport master (
    output i_cmd_valid,
    output i_cmd,
    input  o_cmd_ready,
    input  o_cmd_err
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd,
    output o_cmd_ready,
    output o_cmd_err
  );

endinterface

// File: rtl/tele_tx_timer.sv
// Loadable phase down-counter; done_o flags the last cycle of a phase (value 1).
module tele_tx_timer
  import tele_cmd_tx_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Counts down to zero and parks there until the next load.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/tele_cmd_tx.sv
// Remote power-control transmitter: one accepted command becomes a timed,
// qualified active-low request pulse. Optional abort input: TELE_CMD_ABORT_EN.
module tele_cmd_tx
  import tele_cmd_tx_pkg::*;
#(
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int SETUP_W = DEF_SETUP_W,
  parameter int HOLD_W  = DEF_HOLD_W,
  parameter int GAP_W   = DEF_GAP_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic i_clk_32k,
  input  logic i_rst,
`ifdef TELE_CMD_ABORT_EN
  input  logic i_abort,
`endif
  tele_cmd_tx_if.slave cmd_if,
  output logic o_AST_PWROn_n,
  output logic o_AST_PWROff_n,
  output logic o_AST_Reset_n,
  output logic o_AST_act_n,
  output logic o_busy
);

  tx_state_e        state_q, state_d;
  tele_cmd_t        cmd_q, cmd_d;
  logic             act_n_q, act_n_d;
  logic [2:0]       lines_n_q, lines_n_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             abort_take;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_done;

  // ready_q trails the IDLE decode by one cycle so ready reappears only after
  // the last GAP output cycle, and stays low through reset.
  assign cmd_if.o_cmd_ready = (state_q == ST_IDLE) & ready_q;
  assign cmd_if.o_cmd_err   = err_q;
  assign accept             = cmd_if.i_cmd_valid & cmd_if.o_cmd_ready;

`ifdef TELE_CMD_ABORT_EN
  assign abort_take = i_abort & ((state_q == ST_SETUP) | (state_q == ST_PULSE));
`else
  assign abort_take = 1'b0;
`endif

  tele_tx_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (i_clk_32k),
    .rst_i      (i_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge i_clk_32k) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_PWRON;
      act_n_q   <= 1'b1;
      lines_n_q <= 3'b111;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      act_n_q   <= act_n_d;
      lines_n_q <= lines_n_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  // Each phase loads its length on entry and leaves when the timer shows 1.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (cmd_if.i_cmd != CMD_RSVD)) begin
          cmd_d        = cmd_if.i_cmd;
          state_d      = ST_SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(SETUP_W);
        end
      end
      ST_SETUP: begin
        if (abort_take) begin
          state_d      = ST_HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(HOLD_W);
        end else if (tmr_done) begin
          state_d      = ST_PULSE;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(PULSE_W);
        end
      end
      ST_PULSE: begin
        if (abort_take || tmr_done) begin
          state_d      = ST_HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(HOLD_W);
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          state_d      = ST_GAP;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(GAP_W);
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line levels follow the current state and appear one edge later.
  always_comb begin
    act_n_d   = 1'b1;
    lines_n_d = 3'b111;
    busy_d    = (state_q != ST_IDLE);
    ready_d   = (state_q == ST_IDLE);
    err_d     = accept & (cmd_if.i_cmd == CMD_RSVD);
    case (state_q)
      ST_SETUP, ST_HOLD: begin
        act_n_d = 1'b0;
      end
      ST_PULSE: begin
        act_n_d   = 1'b0;
        lines_n_d = ~cmd_line_mask(cmd_q);
      end
      default: begin
        act_n_d = 1'b1;
      end
    endcase
  end

  assign o_AST_PWROn_n  = lines_n_q[2];
  assign o_AST_PWROff_n = lines_n_q[1];
  assign o_AST_Reset_n  = lines_n_q[0];
  assign o_AST_act_n    = act_n_q;
  assign o_busy         = busy_q;

endmodule
